down_timer_counter: RTL and testbench
=====================================

Name: down_timer_counter

Overview:
- Loadable, programmable down-counter/timer; the count-down counterpart to the team's up-counting ripple counter.
- Loads a start value, decrements once per enabled clock, and pulses done on reaching zero.
- Optional auto-reload gives a periodic tick.
- Fully synchronous to a single clock; used as a general delay/interval source next to the counter blocks.

Parameters:
- WIDTH, 4, width of count value, load value and q output.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  load load_val and begin counting; sampled each rising edge.
- stop  input  1  abort counting, return to IDLE; sampled each rising edge.
- enable  input  1  count-enable in RUN; 0 = hold q.
- auto_reload  input  1  1 = reload and keep running on terminal count; sampled live each cycle.
- load_val  input  WIDTH  start/reload value, captured on start.
- q  output  WIDTH  current count, registered.
- busy  output  1  1 while in RUN, registered.
- done  output  1  one-cycle terminal-count pulse, registered.

Behaviour:
- Reset:
  - reset=0 immediately (asynchronously) forces q=0, busy=0, done=0, reload register=0, state=IDLE.
  - The block leaves reset on the first rising edge after reset=1.
- States: IDLE (busy=0), RUN (busy=1). busy is a registered state decode.
- done defaults to 0 every cycle unless set by a terminal-count or zero-load event below.
- Priority per edge: stop > start > terminal count > decrement.
- IDLE:
  - start=1, load_val!=0: q<=load_val, reload<=load_val, go RUN.
  - start=1, load_val==0: q<=0, done<=1, stay IDLE (zero-length timer).
  - Otherwise q holds its last value.
- RUN, stop=1:
  - Go IDLE, q holds, done=0.
  - stop in IDLE has no effect.
- RUN, start=1 (restart):
  - q<=load_val, reload<=load_val, done=0.
  - Stay RUN; if load_val==0, apply the IDLE zero-load rule and go IDLE.
- RUN, enable=0: q holds, no done.
- RUN, enable=1, q>1: q<=q-1.
- RUN, enable=1, q==1 (terminal count): done<=1, and
  - auto_reload=1: q<=reload, stay RUN.
  - auto_reload=0: q<=0, go IDLE.
- Latency:
  - start at edge k with load_val=N and enable held high: q=N after edge k.
  - done=1 and q=0 (or N if reloading) after edge k+N; done drops after edge k+N+1.
  - Auto-reload period is exactly N cycles.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; never decrements below 0.
  - load_val=2^WIDTH-1 is legal: 15 cycles at WIDTH=4.
- enable=0 on the terminal-count cycle defers done until the next enabled cycle.
- Reset asserted mid-RUN aborts silently: no done, all outputs 0.
- start and stop together: stop wins, block ends in IDLE.

Test Plan:
- Reset/basic: reset=0 for 15 time units then 1; pulse start with load_val=5, enable=1, auto_reload=0 -> q 5,4,3,2,1,0 on consecutive edges; done high one cycle coincident with q=0; busy 1 for 5 cycles then 0.
- Auto-reload: load_val=3, auto_reload=1, enable=1 -> q 3,2,1,3,2,1,...; done pulses every 3 cycles. Drop auto_reload -> next terminal count leaves q=0, busy=0.
- Enable gating: load_val=4, enable toggled 1,0,0,1,1,1 -> q 4,3,3,3,2,1,0; done exactly once, when q becomes 0.
- Restart/stop priority:
  - Mid-count at q=2, start with load_val=9 -> q=9, no done.
  - Later, start=1 and stop=1 same edge -> IDLE, q held, busy=0, done=0.
- Boundaries:
  - start with load_val=0 -> done pulse, q=0, busy stays 0.
  - load_val=15 -> done after exactly 15 enabled cycles.
- Async reset mid-run: at q=6, reset=0 between edges -> q=0, busy=0 immediately; no done after release.

Source files
------------

// File: rtl/down_timer_counter.sv
// Purpose: loadable down-counter/timer with terminal-count pulse and optional auto-reload.
// Latency: q shows load_val one edge after start; done pulses N enabled edges later.
// Backpressure: none; enable=0 freezes the count, stop aborts to IDLE.
module down_timer_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    // State, count, reload value and done pulse registers; reset clears everything silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; priority is stop > start > terminal count > decrement.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // stop outranks start even in IDLE, so start+stop together loads nothing
                if (start && !stop) begin
                    if (load_val != CNT_ZERO) begin
                        cnt_d    = load_val;
                        reload_d = load_val;
                        state_d  = ST_RUN;
                    end else begin
                        // zero-length timer: immediate terminal count, never enters RUN
                        cnt_d  = CNT_ZERO;
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    if (load_val != CNT_ZERO) begin
                        cnt_d    = load_val;
                        reload_d = load_val;
                    end else begin
                        cnt_d   = CNT_ZERO;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_ZERO) begin
                    // unreachable in normal operation; recover rather than wrap below zero
                    state_d = ST_IDLE;
                end else if (enable) begin
                    if (cnt_q == CNT_ONE) begin
                        done_d = 1'b1;
                        if (auto_reload) begin
                            cnt_d = reload_q;
                        end else begin
                            cnt_d   = CNT_ZERO;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; busy is a decode of the state flop.
    always_comb begin
        q    = cnt_q;
        busy = (state_q == ST_RUN);
        done = done_q;
    end

endmodule

// File: tb/tb_down_timer_counter.sv
// Purpose: self-checking bench for down_timer_counter using an expected-result queue.
// Latency: one comparison set per clock edge, sampled 1 time unit after the rising edge.
// Backpressure: not applicable; inputs are driven on the falling edge.
module tb_down_timer_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic             stop;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    down_timer_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .enable      (enable),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .q           (q),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, push the expected post-edge outputs, then pop and compare.
    task automatic step(input logic st, input logic sp, input logic en, input logic ar,
                        input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] eq,
                        input logic eb, input logic ed, input string tag);
        exp_t e;
        @(negedge clk);
        start       = st;
        stop        = sp;
        enable      = en;
        auto_reload = ar;
        load_val    = lv;
        e.tag  = tag;
        e.q    = eq;
        e.busy = eb;
        e.done = ed;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_q"},    32'(q),    32'(e.q));
            check({e.tag, "_busy"}, 32'(busy), 32'(e.busy));
            check({e.tag, "_done"}, 32'(done), 32'(e.done));
        end
    endtask

    // Convenience: plain counting cycle with enable/auto_reload only.
    task automatic run(input logic en, input logic ar, input logic [WIDTH-1:0] eq,
                       input logic eb, input logic ed, input string tag);
        step(1'b0, 1'b0, en, ar, 4'd0, eq, eb, ed, tag);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        enable      = 1'b0;
        auto_reload = 1'b0;
        load_val    = '0;

        #2;
        check("rst_q",    32'(q),    32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #13;
        reset = 1'b1;

        // basic count from 5
        step(1, 0, 1, 0, 4'd5, 4'd5, 1, 0, "basic_ld");
        run(1, 0, 4'd4, 1, 0, "basic_4");
        run(1, 0, 4'd3, 1, 0, "basic_3");
        run(1, 0, 4'd2, 1, 0, "basic_2");
        run(1, 0, 4'd1, 1, 0, "basic_1");
        run(1, 0, 4'd0, 0, 1, "basic_tc");
        run(1, 0, 4'd0, 0, 0, "basic_after");

        // auto-reload with period 3, then drop auto_reload
        step(1, 0, 1, 1, 4'd3, 4'd3, 1, 0, "ar_ld");
        run(1, 1, 4'd2, 1, 0, "ar_2a");
        run(1, 1, 4'd1, 1, 0, "ar_1a");
        run(1, 1, 4'd3, 1, 1, "ar_tc1");
        run(1, 1, 4'd2, 1, 0, "ar_2b");
        run(1, 1, 4'd1, 1, 0, "ar_1b");
        run(1, 1, 4'd3, 1, 1, "ar_tc2");
        run(1, 0, 4'd2, 1, 0, "ar_2c");
        run(1, 0, 4'd1, 1, 0, "ar_1c");
        run(1, 0, 4'd0, 0, 1, "ar_final");

        // enable gating 1,0,0,1,1,1
        step(1, 0, 1, 0, 4'd4, 4'd4, 1, 0, "en_ld");
        run(1, 0, 4'd3, 1, 0, "en_1");
        run(0, 0, 4'd3, 1, 0, "en_0a");
        run(0, 0, 4'd3, 1, 0, "en_0b");
        run(1, 0, 4'd2, 1, 0, "en_1b");
        run(1, 0, 4'd1, 1, 0, "en_1c");
        run(1, 0, 4'd0, 0, 1, "en_tc");

        // enable low on the terminal-count cycle defers done
        step(1, 0, 1, 0, 4'd2, 4'd2, 1, 0, "def_ld");
        run(1, 0, 4'd1, 1, 0, "def_1");
        run(0, 0, 4'd1, 1, 0, "def_hold");
        run(1, 0, 4'd0, 0, 1, "def_tc");

        // restart mid-count, then start+stop together
        step(1, 0, 1, 0, 4'd5, 4'd5, 1, 0, "rs_ld");
        run(1, 0, 4'd4, 1, 0, "rs_4");
        run(1, 0, 4'd3, 1, 0, "rs_3");
        run(1, 0, 4'd2, 1, 0, "rs_2");
        step(1, 0, 1, 0, 4'd9, 4'd9, 1, 0, "rs_restart");
        run(1, 0, 4'd8, 1, 0, "rs_8");
        run(1, 0, 4'd7, 1, 0, "rs_7");
        step(1, 1, 1, 0, 4'd3, 4'd7, 0, 0, "rs_startstop");
        run(1, 0, 4'd7, 0, 0, "rs_idle_hold");
        step(0, 1, 1, 0, 4'd0, 4'd7, 0, 0, "stop_in_idle");

        // zero-length load from IDLE and as a restart in RUN
        step(1, 0, 1, 0, 4'd0, 4'd0, 0, 1, "zero_idle");
        run(1, 0, 4'd0, 0, 0, "zero_after");
        step(1, 0, 1, 0, 4'd2, 4'd2, 1, 0, "zero_run_ld");
        step(1, 0, 1, 0, 4'd0, 4'd0, 0, 1, "zero_restart");
        run(1, 0, 4'd0, 0, 0, "zero_restart_after");

        // full-scale load: 15 enabled cycles to done
        step(1, 0, 1, 0, 4'd15, 4'd15, 1, 0, "max_ld");
        for (int i = 14; i >= 1; i--) begin
            run(1, 0, 4'(i), 1, 0, "max_cnt");
        end
        run(1, 0, 4'd0, 0, 1, "max_tc");

        // asynchronous reset mid-run at q=6
        step(1, 0, 1, 0, 4'd8, 4'd8, 1, 0, "ar_rst_ld");
        run(1, 0, 4'd7, 1, 0, "ar_rst_7");
        run(1, 0, 4'd6, 1, 0, "ar_rst_6");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_q",    32'(q),    32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        #1;
        reset = 1'b1;
        run(1, 0, 4'd0, 0, 0, "post_rst_a");
        run(1, 0, 4'd0, 0, 0, "post_rst_b");

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
